// File: rtl/mod_exp_engine.sv
// Montgomery modular exponentiation engine: C = M^E mod N.
// Operands are shifted in word-serially, LSW first. The result is shifted out on res_out.
// The host supplies r = R mod N, t = R^2 mod N and nprime0 = -N^-1 mod 2^DATA_WIDTH,
// where R = 2^(NWORDS*DATA_WIDTH). N must be odd.
// The MonPro unit is CIOS with one shared DWxDW multiplier, so it does one MAC per cycle.
//
// exp_state        | meaning
// INIT (0)         | idle, waiting for startInput
// LOAD_M_E (1)     | shifting operand words in until startCompute
// LOAD_N (2)       | reserved code, never entered
// WAIT_COMPUTE (3) | latch nprime0
// CALC_M_BAR (4)   | m_bar = MonPro(M, t), then c_bar = r
// GET_K_E (5)      | scan E downward for the highest set bit
// BIGLOOP (6)      | c_bar = MonPro(c_bar, c_bar)
// CALC_C_BAR_M_BAR (7) | c_bar = MonPro(c_bar, m_bar)
// CALC_C_BAR_1 (8) | C = MonPro(c_bar, 1)
// COMPLETE (9)     | result ready, waiting for getResult
// OUTPUT_RESULT (10) | one result word per cycle on res_out
// TERMINAL (11)    | hold until reset
//
// state (MonPro)   | meaning
// 0                | idle
// 1                | clear accumulator
// 2                | word loop (multiply pass, quotient, reduce pass)
// 3                | conditional subtract of N
// 4                | done, result valid in mp_res for one cycle
module mod_exp_engine #(
    parameter int DATA_WIDTH = 64,
    parameter int NWORDS     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] m_buf,
    input  logic [DATA_WIDTH-1:0] e_buf,
    input  logic [DATA_WIDTH-1:0] n_buf,
    input  logic [DATA_WIDTH-1:0] r_buf,
    input  logic [DATA_WIDTH-1:0] t_buf,
    input  logic [DATA_WIDTH-1:0] nprime0,
    input  logic                  startInput,
    input  logic                  startCompute,
    input  logic                  getResult,
    output logic [4:0]            exp_state,
    output logic [3:0]            state,
    output logic [DATA_WIDTH-1:0] res_out
);

    localparam int DW  = DATA_WIDTH;
    localparam int IW  = $clog2(NWORDS);
    localparam int LDW = $clog2(DW);
    localparam int BW  = IW + LDW;
    localparam int CW  = $clog2(NWORDS + 1);
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    localparam logic [1:0] PH_MUL = 2'd0;  // multiply pass; in subtract: word subtract
    localparam logic [1:0] PH_Q   = 2'd1;  // quotient digit; in subtract: select result
    localparam logic [1:0] PH_RED = 2'd2;  // reduce pass

    typedef enum logic [4:0] {
        INIT             = 5'd0,
        LOAD_M_E         = 5'd1,
        LOAD_N           = 5'd2,
        WAIT_COMPUTE     = 5'd3,
        CALC_M_BAR       = 5'd4,
        GET_K_E          = 5'd5,
        BIGLOOP          = 5'd6,
        CALC_C_BAR_M_BAR = 5'd7,
        CALC_C_BAR_1     = 5'd8,
        COMPLETE         = 5'd9,
        OUTPUT_RESULT    = 5'd10,
        TERMINAL         = 5'd11
    } exp_t;

    typedef enum logic [3:0] {
        MP_IDLE = 4'd0,
        MP_INIT = 4'd1,
        MP_LOOP = 4'd2,
        MP_RED  = 4'd3,
        MP_DONE = 4'd4
    } mp_t;

    typedef logic [DW-1:0] word_t;

    exp_t  ex_q;
    mp_t   mul_q;

    word_t m_reg  [NWORDS];
    word_t e_reg  [NWORDS];
    word_t n_reg  [NWORDS];
    word_t r_reg  [NWORDS];
    word_t t_reg  [NWORDS];
    word_t m_bar  [NWORDS];
    word_t c_bar  [NWORDS];
    word_t result [NWORDS];
    word_t np0;

    logic [BW-1:0] k_idx;
    logic [CW-1:0] out_cnt;

    word_t          t_acc  [NWORDS];
    word_t          mp_res [NWORDS];
    word_t          t_hi;
    logic           t_top;
    word_t          carry;
    word_t          m_q;
    logic           borrow;
    logic [IW-1:0]  i_w;
    logic [IW-1:0]  j_w;
    logic [1:0]     phase;

    word_t           a_word, b_word, mul_x, mul_y;
    logic [2*DW-1:0] prod, mac;
    logic [DW:0]     top_sum, diff;
    logic            mp_go, mp_done, e_bit;

    assign exp_state = ex_q;
    assign state     = mul_q;

    assign mp_go   = ex_q inside {CALC_M_BAR, BIGLOOP, CALC_C_BAR_M_BAR, CALC_C_BAR_1};
    assign mp_done = (mul_q == MP_DONE);
    assign e_bit   = e_reg[k_idx[BW-1:LDW]][k_idx[LDW-1:0]];

    assign prod    = {{DW{1'b0}}, mul_x} * {{DW{1'b0}}, mul_y};
    assign mac     = prod + {{DW{1'b0}}, t_acc[j_w]} + {{DW{1'b0}}, carry};
    assign top_sum = {1'b0, t_hi} + {1'b0, mac[2*DW-1:DW]};
    assign diff    = {1'b0, t_acc[j_w]} - {1'b0, n_reg[j_w]} - {{DW{1'b0}}, borrow};

    // Select the MonPro operand words for the current step and steer the shared multiplier.
    always_comb begin
        a_word = '0;
        b_word = '0;
        case (ex_q)
            CALC_M_BAR: begin
                a_word = m_reg[j_w];
                b_word = t_reg[i_w];
            end
            BIGLOOP: begin
                a_word = c_bar[j_w];
                b_word = c_bar[i_w];
            end
            CALC_C_BAR_M_BAR: begin
                a_word = c_bar[j_w];
                b_word = m_bar[i_w];
            end
            CALC_C_BAR_1: begin
                a_word = c_bar[j_w];
                b_word = (i_w == '0) ? {{(DW-1){1'b0}}, 1'b1} : '0;
            end
            default: ;
        endcase
        case (phase)
            PH_Q: begin
                mul_x = t_acc[0];
                mul_y = np0;
            end
            PH_RED: begin
                mul_x = m_q;
                mul_y = n_reg[j_w];
            end
            default: begin
                mul_x = a_word;
                mul_y = b_word;
            end
        endcase
    end

    // Main sequencer: operand load, exponent scan, square-and-multiply, result readout.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= INIT;
            m_reg   <= '{default: '0};
            e_reg   <= '{default: '0};
            n_reg   <= '{default: '0};
            r_reg   <= '{default: '0};
            t_reg   <= '{default: '0};
            m_bar   <= '{default: '0};
            c_bar   <= '{default: '0};
            result  <= '{default: '0};
            np0     <= '0;
            k_idx   <= '0;
            out_cnt <= '0;
            res_out <= '0;
        end else begin
            case (ex_q)
                INIT: if (startInput) ex_q <= LOAD_M_E;
                LOAD_M_E: begin
                    if (startCompute) begin
                        ex_q <= WAIT_COMPUTE;
                    end else begin
                        for (int w = 0; w < NWORDS - 1; w++) begin
                            m_reg[w] <= m_reg[w+1];
                            e_reg[w] <= e_reg[w+1];
                            n_reg[w] <= n_reg[w+1];
                            r_reg[w] <= r_reg[w+1];
                            t_reg[w] <= t_reg[w+1];
                        end
                        m_reg[NWORDS-1] <= m_buf;
                        e_reg[NWORDS-1] <= e_buf;
                        n_reg[NWORDS-1] <= n_buf;
                        r_reg[NWORDS-1] <= r_buf;
                        t_reg[NWORDS-1] <= t_buf;
                    end
                end
                WAIT_COMPUTE: begin
                    np0  <= nprime0;
                    ex_q <= CALC_M_BAR;
                end
                CALC_M_BAR: if (mp_done) begin
                    m_bar <= mp_res;
                    c_bar <= r_reg;
                    k_idx <= BW'(NWORDS * DW - 1);
                    ex_q  <= GET_K_E;
                end
                GET_K_E: begin
                    if (e_bit)              ex_q  <= BIGLOOP;
                    else if (k_idx == '0)   ex_q  <= CALC_C_BAR_1;
                    else                    k_idx <= k_idx - BW'(1);
                end
                BIGLOOP: if (mp_done) begin
                    c_bar <= mp_res;
                    if (e_bit)              ex_q  <= CALC_C_BAR_M_BAR;
                    else if (k_idx == '0)   ex_q  <= CALC_C_BAR_1;
                    else                    k_idx <= k_idx - BW'(1);
                end
                CALC_C_BAR_M_BAR: if (mp_done) begin
                    c_bar <= mp_res;
                    if (k_idx == '0) begin
                        ex_q <= CALC_C_BAR_1;
                    end else begin
                        k_idx <= k_idx - BW'(1);
                        ex_q  <= BIGLOOP;
                    end
                end
                CALC_C_BAR_1: if (mp_done) begin
                    result <= mp_res;
                    ex_q   <= COMPLETE;
                end
                COMPLETE: if (getResult) begin
                    out_cnt <= '0;
                    ex_q    <= OUTPUT_RESULT;
                end
                OUTPUT_RESULT: begin
                    if (out_cnt == CW'(NWORDS)) begin
                        ex_q <= TERMINAL;
                    end else begin
                        res_out <= result[out_cnt[IW-1:0]];
                        out_cnt <= out_cnt + CW'(1);
                    end
                end
                TERMINAL: ;
                default: ex_q <= INIT;
            endcase
        end
    end

    // MonPro unit: CIOS word loop, then serial subtract of N when the accumulator is >= N.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_q  <= MP_IDLE;
            t_acc  <= '{default: '0};
            mp_res <= '{default: '0};
            t_hi   <= '0;
            t_top  <= 1'b0;
            carry  <= '0;
            m_q    <= '0;
            borrow <= 1'b0;
            i_w    <= '0;
            j_w    <= '0;
            phase  <= PH_MUL;
        end else begin
            case (mul_q)
                MP_IDLE: if (mp_go) mul_q <= MP_INIT;
                MP_INIT: begin
                    t_acc  <= '{default: '0};
                    t_hi   <= '0;
                    t_top  <= 1'b0;
                    carry  <= '0;
                    borrow <= 1'b0;
                    i_w    <= '0;
                    j_w    <= '0;
                    phase  <= PH_MUL;
                    mul_q  <= MP_LOOP;
                end
                MP_LOOP: begin
                    case (phase)
                        PH_MUL: begin
                            t_acc[j_w] <= mac[DW-1:0];
                            carry      <= mac[2*DW-1:DW];
                            if (j_w == LAST) begin
                                t_hi  <= top_sum[DW-1:0];
                                t_top <= top_sum[DW];
                                carry <= '0;
                                j_w   <= '0;
                                phase <= PH_Q;
                            end else begin
                                j_w <= j_w + IW'(1);
                            end
                        end
                        PH_Q: begin
                            m_q   <= prod[DW-1:0];
                            phase <= PH_RED;
                        end
                        default: begin
                            // Word 0 of the reduce pass is zero by construction; the rest shift down.
                            if (j_w != '0) t_acc[j_w - IW'(1)] <= mac[DW-1:0];
                            carry <= mac[2*DW-1:DW];
                            if (j_w == LAST) begin
                                t_acc[LAST] <= top_sum[DW-1:0];
                                t_hi  <= {{(DW-1){1'b0}}, t_top} + {{(DW-1){1'b0}}, top_sum[DW]};
                                t_top <= 1'b0;
                                carry <= '0;
                                j_w   <= '0;
                                phase <= PH_MUL;
                                if (i_w == LAST) mul_q <= MP_RED;
                                else             i_w   <= i_w + IW'(1);
                            end else begin
                                j_w <= j_w + IW'(1);
                            end
                        end
                    endcase
                end
                MP_RED: begin
                    if (phase == PH_MUL) begin
                        mp_res[j_w] <= diff[DW-1:0];
                        borrow      <= diff[DW];
                        if (j_w == LAST) phase <= PH_Q;
                        else             j_w   <= j_w + IW'(1);
                    end else begin
                        // Keep the unsubtracted value only when it was already below N.
                        if (t_hi == '0 && borrow) mp_res <= t_acc;
                        phase <= PH_MUL;
                        mul_q <= MP_DONE;
                    end
                end
                MP_DONE: mul_q <= MP_IDLE;
                default: mul_q <= MP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed bench for mod_exp_engine: a 4-word instance for most cases and a full 64-word
// instance for one end-to-end exponentiation. Modulus is 77 throughout.
module tb_mod_exp_engine;

    localparam int SNW = 4;
    localparam int BNW = 64;
    localparam logic [63:0] NMOD = 64'd77;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_reset = 1'b1, s_si = 1'b0, s_sc = 1'b0, s_gr = 1'b0;
    logic [63:0] s_m = '0, s_e = '0, s_n = '0, s_r = '0, s_t = '0, s_np = '0;
    logic [4:0]  s_exp;
    logic [3:0]  s_st;
    logic [63:0] s_res;

    logic        b_reset = 1'b1, b_si = 1'b0, b_sc = 1'b0, b_gr = 1'b0;
    logic [63:0] b_m = '0, b_e = '0, b_n = '0, b_r = '0, b_t = '0, b_np = '0;
    logic [4:0]  b_exp;
    logic [3:0]  b_st;
    logic [63:0] b_res;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [63:0] np_val, s_rv, s_tv, b_rv, b_tv;

    mod_exp_engine #(.DATA_WIDTH(64), .NWORDS(SNW)) dut_small (
        .clk(clk), .reset(s_reset),
        .m_buf(s_m), .e_buf(s_e), .n_buf(s_n), .r_buf(s_r), .t_buf(s_t), .nprime0(s_np),
        .startInput(s_si), .startCompute(s_sc), .getResult(s_gr),
        .exp_state(s_exp), .state(s_st), .res_out(s_res)
    );

    mod_exp_engine #(.DATA_WIDTH(64), .NWORDS(BNW)) dut_big (
        .clk(clk), .reset(b_reset),
        .m_buf(b_m), .e_buf(b_e), .n_buf(b_n), .r_buf(b_r), .t_buf(b_t), .nprime0(b_np),
        .startInput(b_si), .startCompute(b_sc), .getResult(b_gr),
        .exp_state(b_exp), .state(b_st), .res_out(b_res)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] pow2mod(input int bits);
        logic [63:0] v = 64'd1;
        for (int b = 0; b < bits; b++) v = (v * 2) % NMOD;
        return v;
    endfunction

    function automatic logic [63:0] neg_inv(input logic [63:0] n);
        logic [63:0] x = n;
        for (int it = 0; it < 6; it++) x = x * (64'd2 - n * x);
        return -x;
    endfunction

    task automatic small_reset();
        @(negedge clk); s_reset = 1'b1;
        @(negedge clk); s_reset = 1'b0;
    endtask

    task automatic load_small(input logic [63:0] m, input logic [63:0] e, input int garbage);
        @(negedge clk); s_si = 1'b1;
        @(negedge clk); s_si = 1'b0;
        for (int w = 0; w < garbage + SNW; w++) begin
            if (w < garbage) begin
                s_m = {$urandom, $urandom};
                s_e = {$urandom, $urandom};
                s_n = {$urandom, $urandom};
                s_r = {$urandom, $urandom};
                s_t = {$urandom, $urandom};
            end else begin
                s_m = (w == garbage) ? m    : 64'd0;
                s_e = (w == garbage) ? e    : 64'd0;
                s_n = (w == garbage) ? NMOD : 64'd0;
                s_r = (w == garbage) ? s_rv : 64'd0;
                s_t = (w == garbage) ? s_tv : 64'd0;
            end
            @(negedge clk);
        end
        s_sc = 1'b1;
        @(negedge clk); s_sc = 1'b0;
    endtask

    task automatic finish_small(input string tag, input logic [63:0] w0, input int gr_delay);
        int cyc = 0;
        while (s_exp !== 5'd9 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_complete"}, 64'(s_exp), 64'd9);
        if (s_exp === 5'd9) begin
            for (int d = 0; d < gr_delay; d++) begin
                @(negedge clk);
                check({tag, "_hold_complete"}, 64'(s_exp), 64'd9);
            end
            s_gr = 1'b1;
            @(negedge clk); s_gr = 1'b0;
            check({tag, "_out_state"}, 64'(s_exp), 64'd10);
            check({tag, "_res_before_word0"}, s_res, 64'd0);
            for (int j = 0; j < SNW; j++) begin
                @(negedge clk);
                check($sformatf("%s_word%0d", tag, j), s_res, (j == 0) ? w0 : 64'd0);
            end
            @(negedge clk);
            check({tag, "_terminal"}, 64'(s_exp), 64'd11);
        end
    endtask

    task automatic run_small(input string tag, input logic [63:0] m, input logic [63:0] e,
                             input int garbage, input logic [63:0] w0, input int gr_delay);
        small_reset();
        load_small(m, e, garbage);
        finish_small(tag, w0, gr_delay);
    endtask

    initial begin
        int cyc;
        np_val = neg_inv(NMOD);
        s_rv   = pow2mod(SNW * 64);
        s_tv   = (s_rv * s_rv) % NMOD;
        b_rv   = pow2mod(BNW * 64);
        b_tv   = (b_rv * b_rv) % NMOD;
        s_np   = np_val;
        b_np   = np_val;

        repeat (3) @(negedge clk);
        s_reset = 1'b0;
        @(negedge clk);
        check("reset_exp_state", 64'(s_exp), 64'd0);
        check("reset_state", 64'(s_st), 64'd0);
        check("reset_res_out", s_res, 64'd0);

        // 64 words streamed into a 4-word engine: the first 60 are discarded.
        run_small("m8_e13", 64'd8, 64'd13, 64 - SNW, 64'd50, 2);
        run_small("e0", 64'd8, 64'd0, 0, 64'd1, 0);
        run_small("m8_e1", 64'd8, 64'd1, 0, 64'd8, 0);
        run_small("m90_e1_garbage", 64'd90, 64'd1, 5, 64'd13, 0);

        // Abort in the middle of a squaring.
        small_reset();
        load_small(64'd8, 64'd13, 0);
        cyc = 0;
        while (s_exp !== 5'd6 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_bigloop", 64'(s_exp), 64'd6);
        repeat (3) @(negedge clk);
        check("bigloop_mult_busy", 64'(s_st), 64'd2);
        s_reset = 1'b1;
        @(negedge clk); s_reset = 1'b0;
        check("abort_exp_state", 64'(s_exp), 64'd0);
        check("abort_state", 64'(s_st), 64'd0);
        check("abort_res_out", s_res, 64'd0);
        run_small("after_abort", 64'd8, 64'd13, 0, 64'd50, 0);

        // Full-width engine: M=8, E=1 -> C=8.
        @(negedge clk); b_reset = 1'b0;
        @(negedge clk); b_si = 1'b1;
        @(negedge clk); b_si = 1'b0;
        for (int w = 0; w < BNW; w++) begin
            b_m = (w == 0) ? 64'd8  : 64'd0;
            b_e = (w == 0) ? 64'd1  : 64'd0;
            b_n = (w == 0) ? NMOD   : 64'd0;
            b_r = (w == 0) ? b_rv   : 64'd0;
            b_t = (w == 0) ? b_tv   : 64'd0;
            @(negedge clk);
        end
        b_sc = 1'b1;
        @(negedge clk); b_sc = 1'b0;
        cyc = 0;
        while (b_exp !== 5'd9 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
        end
        check("big_complete", 64'(b_exp), 64'd9);
        if (b_exp === 5'd9) begin
            b_gr = 1'b1;
            @(negedge clk); b_gr = 1'b0;
            check("big_out_state", 64'(b_exp), 64'd10);
            for (int j = 0; j < BNW; j++) begin
                @(negedge clk);
                check($sformatf("big_word%0d", j), b_res, (j == 0) ? 64'd8 : 64'd0);
            end
            @(negedge clk);
            check("big_terminal", 64'(b_exp), 64'd11);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
